// File: rtl/spi_frame_engine.sv
// rtl/spi_frame_engine.sv - SPI mode-0 16-bit command/data frame decoder with register strobes
//
// Purpose: consumes synchronized CS_N/MOSI levels and single-cycle SCLK edge
// pulses, decodes {rw, addr} + data frames, issues one-clk register read/write
// strobes and shifts read data out on MISO.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   cs_n           synchronized chip select (active low)
//   sclk_rise      one-clk pulse per SCLK rising edge
//   sclk_fall      one-clk pulse per SCLK falling edge
//   mosi           synchronized MOSI level
//   miso, miso_oe  serial read data and its output enable
//   reg_addr       latched register address
//   reg_wdata      latched write data
//   reg_wr, reg_rd one-clk write / read strobes
//   reg_rdata      read data, valid the clk after reg_rd
//   frame_err      one-clk pulse when a frame ends with 1..15 bits
module spi_frame_engine #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk_rise,
    input  logic              sclk_fall,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [4:0] CMD_LAST   = 5'(DATA_W - 1);
    localparam logic [4:0] FRAME_LAST = 5'(2 * DATA_W - 1);
    localparam logic [4:0] FRAME_BITS = 5'(2 * DATA_W);

    state_t            state;
    logic [4:0]        bit_cnt;
    // Shift registers hold only the bits received so far; the final bit is
    // taken straight from mosi on the completing rise.
    logic [DATA_W-2:0] cmd_sr;
    logic [DATA_W-2:0] wdata_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              is_read;
    logic              rd_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            wdata_sr   <= '0;
            tx_sr      <= '0;
            is_read    <= 1'b0;
            rd_capture <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            frame_err  <= 1'b0;
            miso_oe    <= !cs_n;
            rd_capture <= reg_rd;
            if (rd_capture) begin
                tx_sr <= reg_rdata;
            end

            if (cs_n) begin
                // Frame boundary: a partial frame is an error, 0 or a full
                // (possibly over-length, saturated) frame is not.
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                miso      <= 1'b0;
                frame_err <= (bit_cnt != 5'd0) && (bit_cnt != FRAME_BITS);
            end else begin
                case (state)
                    ST_IDLE, ST_CMD: begin
                        state <= ST_CMD;
                        miso  <= 1'b0;
                        if (sclk_rise) begin
                            cmd_sr  <= {cmd_sr[DATA_W-3:0], mosi};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == CMD_LAST) begin
                                state    <= ST_DATA;
                                is_read  <= !cmd_sr[DATA_W-2];
                                reg_rd   <= !cmd_sr[DATA_W-2];
                                reg_addr <= {cmd_sr[ADDR_W-2:0], mosi};
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            wdata_sr <= {wdata_sr[DATA_W-3:0], mosi};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == FRAME_LAST) begin
                                state <= ST_DONE;
                                miso  <= 1'b0;
                                if (!is_read) begin
                                    reg_wdata <= {wdata_sr, mosi};
                                    reg_wr    <= 1'b1;
                                end
                            end
                        end else if (sclk_fall && is_read) begin
                            // The first data fall can land in the very cycle
                            // read data is captured, so forward it directly.
                            if (rd_capture) begin
                                miso  <= reg_rdata[DATA_W-1];
                                tx_sr <= {reg_rdata[DATA_W-2:0], 1'b0};
                            end else begin
                                miso  <= tx_sr[DATA_W-1];
                                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    ST_DONE: begin
                        miso <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_engine.sv
// tb/tb_spi_frame_engine.sv - scoreboard bench for spi_frame_engine with randomized SPI frames
module tb_spi_frame_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk_rise = 1'b0;
    logic       sclk_fall = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_frame_engine #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic       miso_q[$];
    logic [7:0] mem[128];

    int   vectors = 0;
    int   miscompares = 0;
    logic miso_chk = 1'b0;
    logic mon_en = 1'b0;
    logic oe_valid = 1'b0;
    logic last_cs_n = 1'b1;
    logic rd_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Register-file responder: data valid the clk after reg_rd, garbage otherwise.
    always @(negedge clk) begin
        if (reg_rd) begin
            reg_rdata = mem[reg_addr];
            rd_hold   = 1'b1;
        end else if (rd_hold) begin
            rd_hold = 1'b0;
        end else begin
            reg_rdata = 8'($urandom);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        exp_t e;
        logic m;
        if (mon_en) begin
            if (oe_valid) check("miso_oe", 32'(miso_oe), 32'(!last_cs_n));
            if (reg_wr) begin
                if (exp_q.size() == 0) check("unexpected_reg_wr", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("wr_kind", 32'(e.kind), 32'(K_WR));
                    check("wr_addr", 32'(reg_addr), 32'(e.addr));
                    check("wr_data", 32'(reg_wdata), 32'(e.data));
                end
            end
            if (reg_rd) begin
                if (exp_q.size() == 0) check("unexpected_reg_rd", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rd_kind", 32'(e.kind), 32'(K_RD));
                    check("rd_addr", 32'(reg_addr), 32'(e.addr));
                end
            end
            if (frame_err) begin
                if (exp_q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("err_kind", 32'(e.kind), 32'(K_ERR));
                end
            end
            if (miso_chk) begin
                if (miso_q.size() == 0) check("miso_queue_underflow", 32'd1, 32'd0);
                else begin
                    m = miso_q.pop_front();
                    check("miso_bit", 32'(miso), 32'(m));
                end
            end
        end
        oe_valid  = !rst;
        last_cs_n = cs_n;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic exp_m, input logic simul);
        mosi = b;
        tick($urandom_range(1, 2));
        sclk_rise = 1'b1;
        sclk_fall = simul;
        miso_chk  = 1'b1;
        miso_q.push_back(exp_m);
        tick();
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        miso_chk  = 1'b0;
        tick($urandom_range(1, 3));
        sclk_fall = 1'b1;
        tick();
        sclk_fall = 1'b0;
    endtask

    // Behavioural frame model: expectations follow from the frame contents only.
    task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                         input logic simul_en, input logic finish_frame);
        logic [6:0] a;
        logic       rw;
        logic       b;
        logic       em;
        logic       s;
        exp_t       e;
        a = cmd[6:0];
        rw = cmd[7];
        if (nbits >= 8 && !rw) begin
            e.kind = K_RD; e.addr = a; e.data = 8'h00;
            exp_q.push_back(e);
        end
        if (nbits >= 16 && rw) begin
            e.kind = K_WR; e.addr = a; e.data = data;
            exp_q.push_back(e);
        end
        if (finish_frame && nbits >= 1 && nbits <= 15) begin
            e.kind = K_ERR; e.addr = 7'h00; e.data = 8'h00;
            exp_q.push_back(e);
        end
        cs_n = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) b = cmd[3'(7 - i)];
            else if (i < 16) b = data[3'(15 - i)];
            else b = 1'($urandom);
            em = (!rw && i >= 8 && i < 16) ? mem[a][3'(15 - i)] : 1'b0;
            s = simul_en && (i < 8) && ($urandom_range(0, 3) == 0);
            send_bit(b, em, s);
        end
        if (finish_frame) begin
            tick($urandom_range(1, 2));
            cs_n = 1'b1;
            tick(4);
            if (nbits >= 16 && rw) mem[a] = data;
        end
    endtask

    task automatic idle_edges(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = 1'($urandom);
            sclk_rise = 1'b1;
            sclk_fall = 1'($urandom);
            tick();
            sclk_rise = 1'b0;
            sclk_fall = 1'b0;
            tick(2);
            sclk_fall = 1'b1;
            tick();
            sclk_fall = 1'b0;
            tick();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
        check({tag, "_reg_wr"}, 32'(reg_wr), 32'd0);
        check({tag, "_reg_rd"}, 32'(reg_rd), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        int nb;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

        rst = 1'b1;
        cs_n = 1'b0;
        tick(3);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cs_n = 1'b1;
        mon_en = 1'b1;
        tick(3);

        // Plain write and read frames
        frame(8'h85, 8'h3C, 16, 1'b0, 1'b1);
        mem[7'h12] = 8'hA5;
        frame(8'h12, 8'h00, 16, 1'b0, 1'b1);
        // Truncated write, then a full write must still work
        frame(8'h81, 8'hFF, 13, 1'b0, 1'b1);
        frame(8'h81, 8'h5A, 16, 1'b0, 1'b1);
        // Over-length write
        frame(8'h83, 8'h77, 24, 1'b0, 1'b1);

        // Reset in the middle of a read, after the 11th rise
        frame(8'h12, 8'h00, 11, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cs_n = 1'b1;
        tick(4);
        frame(8'h01, 8'h00, 16, 1'b0, 1'b1);

        // Simultaneous edges during the command byte
        frame(8'hC4, 8'h96, 16, 1'b1, 1'b1);
        frame(8'h2A, 8'h00, 16, 1'b1, 1'b1);

        // Edges with chip select high, then an empty frame
        idle_edges(4);
        frame(8'h00, 8'h00, 0, 1'b0, 1'b1);
        frame(8'h02, 8'h00, 16, 1'b0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6) nb = 16;
            else if (r < 8) nb = $urandom_range(1, 15);
            else nb = $urandom_range(17, 24);
            frame(8'($urandom), 8'($urandom), nb, 1'($urandom), 1'b1);
            if ((k % 6) == 5) idle_edges(2);
        end

        tick(10);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        check("pending_miso", 32'(miso_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
